// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response
// channel plus the fetch slot handed to decode.
interface fetch_unit_if;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_instr_o;

    modport master (
        output imem_req_valid_o,
        output imem_req_addr_o,
        input  imem_req_ready_i,
        input  imem_rsp_valid_i,
        input  imem_rsp_data_i,
        output fetch_valid_o,
        output fetch_pc_o,
        output fetch_instr_o,
        input  fetch_ready_i
    );

    modport slave (
        input  imem_req_valid_o,
        input  imem_req_addr_o,
        output imem_req_ready_i,
        output imem_rsp_valid_i,
        output imem_rsp_data_i,
        input  fetch_valid_o,
        input  fetch_pc_o,
        input  fetch_instr_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a
// one-entry output slot, and redirect with in-flight drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_pc_i,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_e;

    localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_instr_q, slot_instr_d;

    logic        req_valid;
    logic        req_fire;
    logic        xfer;
    logic [31:0] redir_pc;

    // Outputs and handshake qualifiers; everything masked in reset
    always_comb begin
        redir_pc  = redirect_pc_i & 32'hFFFF_FFFC;
        req_valid = rstn_i
                  && (state_q == S_REQ)
                  && (!slot_valid_q || bus.fetch_ready_i)
                  && !redirect_valid_i;
        req_fire  = req_valid && bus.imem_req_ready_i;
        xfer      = slot_valid_q && bus.fetch_ready_i;

        bus.imem_req_valid_o = req_valid;
        bus.imem_req_addr_o  = pc_q;
        bus.fetch_valid_o    = rstn_i && slot_valid_q;
        bus.fetch_pc_o       = slot_pc_q;
        bus.fetch_instr_o    = slot_instr_q;
    end

    // Next-state: FSM, PC sequencing, slot load/drain, redirect
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;

        if (xfer) begin
            slot_valid_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid_i) begin
                    state_d = S_REQ;
                    if (!redirect_valid_i) begin
                        slot_valid_d = 1'b1;
                        slot_pc_d    = req_pc_q;
                        slot_instr_d = bus.imem_rsp_data_i;
                    end
                end else if (redirect_valid_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.imem_rsp_valid_i) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect wins: new PC, and the slot is flushed untransferred
        if (redirect_valid_i) begin
            pc_d         = redir_pc;
            slot_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= S_REQ;
            pc_q         <= RST_PC;
            req_pc_q     <= RST_PC;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= 32'd0;
            slot_instr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstn_i  in  1  reset, synchronous, active-low.
REQ-004 redirect_valid_i  in  1  pipeline redirect (jump/branch taken) request.
REQ-005 redirect_pc_i  in  32  redirect target; bits [1:0] SHALL be ignored and treated as zero.
REQ-006 imem_req_valid_o  out  1  instruction memory request valid.
REQ-007 imem_req_ready_i  in  1  instruction memory accepts request.
REQ-008 imem_req_addr_o  out  32  request word address (byte address, 4-aligned).
REQ-009 imem_rsp_valid_i  in  1  response valid, exactly one per accepted request, arrives in-order at least 1 cycle after acceptance.
REQ-010 imem_rsp_data_i  in  32  fetched instruction word.
REQ-011 fetch_valid_o  out  1  instruction slot to decode valid.
REQ-012 fetch_ready_i  in  1  decode stage accepts slot.
REQ-013 fetch_pc_o  out  32  PC of slot instruction (bus32_t, drives decoder pc_i).
REQ-014 fetch_instr_o  out  32  slot instruction (instruction_t, drives decoder instr_i).

Function
REQ-015 Internal state: pc_q (next fetch address), req_pc_q (address of outstanding request), one-entry output slot (valid, pc, instr), FSM {REQ, WAIT, DRAIN}.
REQ-016 At most one imem request SHALL be outstanding (accepted, response not yet received) at any time.
REQ-017 imem_req_valid_o = (state==REQ) && (!slot_valid || fetch_ready_i) && !redirect_valid_i; imem_req_addr_o = pc_q.
REQ-018 REQ: on req_valid&&req_ready -> req_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), state->WAIT.
REQ-019 WAIT: on imem_rsp_valid_i -> slot<= {1, req_pc_q, imem_rsp_data_i}, state->REQ; slot is guaranteed empty at this point by REQ-017.
REQ-020 DRAIN: on imem_rsp_valid_i -> response discarded (slot unchanged), state->REQ.
REQ-021 imem_rsp_valid_i in state REQ SHALL be ignored (protocol error, no state change).
REQ-022 Slot handshake: slot_valid cleared on fetch_valid_o&&fetch_ready_i unless reloaded the same cycle; fetch_pc_o/fetch_instr_o SHALL hold stable while fetch_valid_o && !fetch_ready_i.
REQ-023 fetch_valid_o = slot_valid; fetch_pc_o/fetch_instr_o = slot contents (don't-care when invalid).
REQ-024 Redirect has highest priority: pc_q<={redirect_pc_i[31:2],2'b00}; slot_valid<=0 even if fetch_ready_i high (no transfer counted).
REQ-025 Redirect in WAIT without same-cycle response -> DRAIN; with same-cycle response -> response discarded, state->REQ.
REQ-026 Redirect in DRAIN -> stay DRAIN (pc_q updated); with same-cycle response -> REQ.
REQ-027 Redirect in REQ -> stay REQ, no request issued that cycle (REQ-017); an unaccepted request MAY be withdrawn on redirect.
REQ-028 Best-case latency: request cycle N, response N+1, fetch_valid_o N+2; sustained throughput one instruction per 2 cycles with 1-cycle memory.

Reset
REQ-029 When rstn_i==0 at a rising edge: pc_q<=RESET_PC, req_pc_q<=RESET_PC, state<=REQ, slot_valid<=0; all other inputs ignored.
REQ-030 During reset cycle outputs SHALL be fetch_valid_o=0, imem_req_valid_o=0 (combinationally masked while rstn_i==0).
REQ-031 Reset mid-WAIT/DRAIN: outstanding response arriving after reset SHALL be ignored (state REQ per REQ-021); memory model is reset together with this block.
REQ-032 First request SHALL issue in the first cycle with rstn_i==1, addr=RESET_PC.

Verification
REQ-033 Reset release, mem ready=1, 1-cycle rsp, fetch_ready=1 -> requests at 0x0,0x4,0x8 every 2 cycles; fetch_pc_o 0x0,0x4,0x8 with matching words.
REQ-034 fetch_ready=0 for 5 cycles after first slot valid -> slot holds pc 0x0 stable, imem_req_valid_o=0, no second request until ready.
REQ-035 Redirect to 0x103 during WAIT for 0x4 -> response for 0x4 dropped, next request addr 0x100, next fetch_pc_o 0x100.
REQ-036 Redirect same cycle as slot handshake (pc 0x8) -> no transfer, slot invalid next cycle, next fetch_pc_o = target.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first addr 0xFFFFFFFC, second addr 0x00000000.
REQ-038 imem_req_ready=0 for 3 cycles, rsp latency 4 -> addr held at 0x0, single outstanding request, slot pc 0x0 correct.
